// File: rtl/pll0_drp_ctrl.sv
// PLLE4_ADV reconfiguration controller: holds the PLL in reset, rewrites the six
// divider/multiplier DRP registers by read-modify-write, releases reset and waits for lock.
module pll0_drp_ctrl #(
    parameter int unsigned RST_HOLD     = 8,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        clk_in0,
    input  logic        reset,
    input  logic        req,
    input  logic [6:0]  cfg_mult,
    input  logic [6:0]  cfg_div0,
    input  logic [6:0]  cfg_div1,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        pll_rst,
    input  logic        pll_locked,
    output logic        locked_out
);

    localparam int unsigned MAX_A   = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
        S_NEXT, S_RELEASE, S_LOCK_WAIT, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       mult_q, mult_d, div0_q, div0_d, div1_q, div1_d;
    logic [15:0]      rd_q, rd_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             den_q, den_d, dwe_q, dwe_d, pll_rst_q, pll_rst_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             sync1_q, sync2_q, locked_q, locked_d;
    logic             accept, err_evt, cfg_bad;
    logic [6:0]       ent_addr, ent_div;
    logic [5:0]       enc_hi, enc_lo;

    assign cfg_bad = (mult_q == 7'd0) || (div0_q == 7'd0) || (div1_q == 7'd0);

    // State and output registers
    always_ff @(posedge clk_in0) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            mult_q    <= '0;
            div0_q    <= '0;
            div1_q    <= '0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            pll_rst_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mult_q    <= mult_d;
            div0_q    <= div0_d;
            div1_q    <= div1_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
            pll_rst_q <= pll_rst_d;
            sync1_q   <= pll_locked;
            sync2_q   <= sync1_q;
            locked_q  <= locked_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mult_d  = mult_q;
        div0_d  = div0_q;
        div1_d  = div1_q;
        rd_d    = rd_q;
        accept  = 1'b0;
        err_evt = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                accept  = 1'b1;
                mult_d  = cfg_mult;
                div0_d  = cfg_div0;
                div1_d  = cfg_div1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                cnt_d = '0;
                if (cfg_bad) begin
                    err_evt = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    idx_d   = '0;
                    state_d = S_RD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    rd_d    = drp_do;
                    state_d = S_WR;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_evt = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR: begin
                cnt_d   = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_evt = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == 3'd5) begin
                    state_d = S_RELEASE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_RD;
                end
            end
            S_RELEASE: begin
                cnt_d   = '0;
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                if (sync2_q) begin
                    state_d = S_FIN;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_evt = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; DRP strobes are decoded from the next state so den lines up with RD/WR
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        den_d     = 1'b0;
        dwe_d     = 1'b0;
        daddr_d   = daddr_q;
        di_d      = di_q;
        pll_rst_d = pll_rst_q;
        ent_addr  = 7'h15;
        ent_div   = mult_q;
        case (idx_d)
            3'd0:    ent_addr = 7'h08;
            3'd1:    ent_addr = 7'h09;
            3'd2:    ent_addr = 7'h0A;
            3'd3:    ent_addr = 7'h0B;
            3'd4:    ent_addr = 7'h14;
            default: ent_addr = 7'h15;
        endcase
        case (idx_d[2:1])
            2'd0:    ent_div = div0_q;
            2'd1:    ent_div = div1_q;
            default: ent_div = mult_q;
        endcase
        enc_hi = ent_div[6:1];
        enc_lo = 6'(ent_div - {1'b0, ent_div[6:1]});
        if (ent_div == 7'd1) begin
            enc_hi = 6'd1;
            enc_lo = 6'd1;
        end
        if (accept) begin
            busy_d = 1'b1;
            err_d  = 1'b0;
        end
        if (err_evt) err_d = 1'b1;
        if (state_q == S_CHECK && !cfg_bad) pll_rst_d = 1'b1;
        if (state_q == S_RELEASE) pll_rst_d = 1'b0;
        if (state_q == S_FIN) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == S_RD || state_d == S_WR) begin
            den_d   = 1'b1;
            dwe_d   = (state_d == S_WR);
            daddr_d = ent_addr;
        end
        if (state_d == S_WR) begin
            di_d = idx_d[0] ? {rd_d[15:8], ent_div[0], (ent_div == 7'd1), rd_d[5:0]}
                            : {rd_d[15:12], enc_hi, enc_lo};
        end
        locked_d = sync2_q & ~busy_d;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign drp_daddr  = daddr_q;
    assign drp_den    = den_q;
    assign drp_dwe    = dwe_q;
    assign drp_di     = di_q;
    assign pll_rst    = pll_rst_q;
    assign locked_out = locked_q;

endmodule
